// File: rtl/pi_loop_controller.sv
// -----------------------------------------------------------------------------
// pi_loop_controller
//
// Runs one proportional-integral update per accepted ADC sample through an
// external 5-stage PI pipeline. The block owns the persistent integral,
// freezes every pipeline operand for the whole pass, saturates the pipeline
// result into the signed DAC code range and hands it to the DAC on a
// valid/ready channel.
//
// Flow: IDLE -> LAUNCH -> WAIT -> OUTPUT -> IDLE. WAIT falls back to IDLE
// with a sticky fault if the pipeline does not answer in TIMEOUT_CYCLES.
//
// Optional feature (compile-time macro):
//   PI_CTRL_ANTI_WINDUP_EN - when defined, a pass whose result saturated
//   (pi_overflow or pi_underflow) does not commit the new integral; the
//   saturated DAC code is still written.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                loop run enable (gates sample acceptance only)
//   clear_integral        level; zeroes the integral in IDLE and overrides
//                         the commit on a completing pass
//   kp, ki, setpoint      gains and target, sampled at accept
//   sample_valid/sample/sample_ready   ADC channel (ready is combinational)
//   pi_start, pi_actual, pi_setpoint,
//   pi_kp, pi_ki, pi_integral_input    pipeline launch and frozen operands
//   pi_result_valid, pi_overflow,
//   pi_underflow, pi_result,
//   pi_integral_result                 pipeline return
//   dac_valid/dac_data/dac_ready       DAC channel
//   integral              committed integral state
//   busy                  controller is not in IDLE
//   fault_timeout         sticky pipeline timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module pi_loop_controller #(
  parameter int INPUT_WIDTH       = 18,
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20,
  parameter int TIMEOUT_CYCLES    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear_integral,
  input  logic [OUTPUT_WIDTH-1:0]      kp,
  input  logic [OUTPUT_WIDTH-1:0]      ki,
  input  logic [INPUT_WIDTH-1:0]       setpoint,
  // ADC channel
  input  logic                         sample_valid,
  input  logic [INPUT_WIDTH-1:0]       sample,
  output logic                         sample_ready,
  // pipeline drive
  output logic                         pi_start,
  output logic [INPUT_WIDTH-1:0]       pi_actual,
  output logic [INPUT_WIDTH-1:0]       pi_setpoint,
  output logic [OUTPUT_WIDTH-1:0]      pi_kp,
  output logic [OUTPUT_WIDTH-1:0]      pi_ki,
  output logic [OUTPUT_WIDTH-1:0]      pi_integral_input,
  // pipeline return
  input  logic                         pi_result_valid,
  input  logic                         pi_overflow,
  input  logic                         pi_underflow,
  input  logic [OUTPUT_WIDTH-1:0]      pi_result,
  input  logic [OUTPUT_WIDTH-1:0]      pi_integral_result,
  // DAC channel
  output logic                         dac_valid,
  output logic [OUTPUT_RANGE_BITS-1:0] dac_data,
  input  logic                         dac_ready,
  // status
  output logic [OUTPUT_WIDTH-1:0]      integral,
  output logic                         busy,
  output logic                         fault_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // wait_cnt counts completed WAIT cycles; the cycle holding this value is
  // the last one allowed before the timeout fires.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Extreme signed DAC codes used when the pipeline reports saturation.
  localparam logic [OUTPUT_RANGE_BITS-1:0] DAC_MAX = {1'b0, {(OUTPUT_RANGE_BITS-1){1'b1}}};
  localparam logic [OUTPUT_RANGE_BITS-1:0] DAC_MIN = {1'b1, {(OUTPUT_RANGE_BITS-1){1'b0}}};

  state_t                         state;
  logic                           armed;
  logic [CNT_W-1:0]               wait_cnt;
  logic [OUTPUT_RANGE_BITS-1:0]   sat_code;
  logic [OUTPUT_WIDTH-1:0]        commit_value;

  // Only the low DAC-width bits of the pipeline result are ever used; the
  // upper bits are covered by the pipeline's own overflow/underflow flags.
  logic unused_result_msbs;
  assign unused_result_msbs = ^pi_result[OUTPUT_WIDTH-1:OUTPUT_RANGE_BITS];

  // The only combinational path from an input to an output: a new sample
  // can be taken in the same cycle the controller returns to IDLE.
  assign sample_ready = enable && (state == S_IDLE);

  // Saturated DAC code for the current pipeline return. Overflow takes
  // priority should a broken pipeline ever raise both flags.
  // NOTE: every always_comb output gets an unconditional default first so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    sat_code = pi_result[OUTPUT_RANGE_BITS-1:0];
    if (pi_overflow) begin
      sat_code = DAC_MAX;
    end else if (pi_underflow) begin
      sat_code = DAC_MIN;
    end
  end

  // Integral value written on a completing pass. clear_integral is applied
  // last so it wins over both the normal commit and anti-windup hold.
  always_comb begin
    commit_value = pi_integral_result;
`ifdef PI_CTRL_ANTI_WINDUP_EN
    if (pi_overflow || pi_underflow) begin
      commit_value = integral;
    end
`else
    // Saturated passes commit the pipeline integral like any other pass.
`endif
    if (clear_integral) begin
      commit_value = '0;
    end
  end

  // Controller FSM with all outputs registered.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too; they drive block outputs
      // and must not expose X to the pipeline before the first accept.
      state             <= S_IDLE;
      armed             <= 1'b0;
      wait_cnt          <= '0;
      pi_start          <= 1'b0;
      pi_actual         <= '0;
      pi_setpoint       <= '0;
      pi_kp             <= '0;
      pi_ki             <= '0;
      pi_integral_input <= '0;
      dac_valid         <= 1'b0;
      dac_data          <= '0;
      integral          <= '0;
      busy              <= 1'b0;
      fault_timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_integral) begin
            integral <= '0;
          end
          if (sample_valid && sample_ready) begin
            // Freeze every operand for the whole pipeline pass.
            pi_actual         <= sample;
            pi_setpoint       <= setpoint;
            pi_kp             <= kp;
            pi_ki             <= ki;
            pi_integral_input <= integral;
            pi_start          <= 1'b1;
            busy              <= 1'b1;
            state             <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // pi_start was raised on the accept edge, so it is high for
          // exactly this one cycle.
          pi_start <= 1'b0;
          armed    <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // A valid still high from the previous pass must be seen low once
          // before a high valid can be trusted as this pass's result.
          if (!pi_result_valid) begin
            armed <= 1'b1;
          end
          if (armed && pi_result_valid) begin
            dac_data  <= sat_code;
            dac_valid <= 1'b1;
            integral  <= commit_value;
            state     <= S_OUTPUT;
          end else if (wait_cnt == WAIT_LAST) begin
            // Abandon the pass: no DAC write and the integral is untouched.
            fault_timeout <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_OUTPUT: begin
          // dac_data is held from the completion edge until the transfer.
          if (dac_ready) begin
            dac_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_loop_controller.sv
// -----------------------------------------------------------------------------
// tb_pi_loop_controller
//
// Drives pi_loop_controller against a behavioural PI pipeline stub and checks
// it with a reference model of the control law and committed integral.
// Directed steps cover nominal latency, saturation, anti-windup (follows the
// PI_CTRL_ANTI_WINDUP_EN macro), DAC backpressure, integral clears, pipeline
// timeout, enable drop and mid-pass reset; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_pi_loop_controller;

  localparam int IW = 18;
  localparam int OW = 32;
  localparam int RB = 20;

`ifdef PI_CTRL_ANTI_WINDUP_EN
  localparam bit ANTI_WINDUP = 1'b1;
`else
  localparam bit ANTI_WINDUP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          clear_integral;
  logic [OW-1:0] kp;
  logic [OW-1:0] ki;
  logic [IW-1:0] setpoint;
  logic          sample_valid;
  logic [IW-1:0] sample;
  logic          sample_ready;
  logic          pi_start;
  logic [IW-1:0] pi_actual;
  logic [IW-1:0] pi_setpoint;
  logic [OW-1:0] pi_kp;
  logic [OW-1:0] pi_ki;
  logic [OW-1:0] pi_integral_input;
  logic          pi_result_valid;
  logic          pi_overflow;
  logic          pi_underflow;
  logic [OW-1:0] pi_result;
  logic [OW-1:0] pi_integral_result;
  logic          dac_valid;
  logic [RB-1:0] dac_data;
  logic          dac_ready;
  logic [OW-1:0] integral;
  logic          busy;
  logic          fault_timeout;

  pi_loop_controller #(
    .INPUT_WIDTH      (IW),
    .OUTPUT_WIDTH     (OW),
    .OUTPUT_RANGE_BITS(RB),
    .TIMEOUT_CYCLES   (15)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .clear_integral    (clear_integral),
    .kp                (kp),
    .ki                (ki),
    .setpoint          (setpoint),
    .sample_valid      (sample_valid),
    .sample            (sample),
    .sample_ready      (sample_ready),
    .pi_start          (pi_start),
    .pi_actual         (pi_actual),
    .pi_setpoint       (pi_setpoint),
    .pi_kp             (pi_kp),
    .pi_ki             (pi_ki),
    .pi_integral_input (pi_integral_input),
    .pi_result_valid   (pi_result_valid),
    .pi_overflow       (pi_overflow),
    .pi_underflow      (pi_underflow),
    .pi_result         (pi_result),
    .pi_integral_result(pi_integral_result),
    .dac_valid         (dac_valid),
    .dac_data          (dac_data),
    .dac_ready         (dac_ready),
    .integral          (integral),
    .busy              (busy),
    .fault_timeout     (fault_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // PI control law: new integral = I + ki*(actual-setpoint),
  //                 result       = kp*(actual-setpoint) + new integral.
  // ---------------------------------------------------------------------------
  function automatic int pi_new_integral(input int actual, input int target,
                                         input int gain_i, input int integ);
    return integ + gain_i * (actual - target);
  endfunction

  function automatic int pi_out(input int actual, input int target,
                                input int gain_p, input int new_integ);
    return gain_p * (actual - target) + new_integ;
  endfunction

  // ---------------------------------------------------------------------------
  // Ideal 5-stage pipeline: captures operands on pi_start, drops valid, and
  // raises valid with the answer four edges later. Valid then stays high
  // (stale) until the next start. stub_stuck holds valid high permanently.
  // ---------------------------------------------------------------------------
  logic          stub_valid;
  logic          stub_stuck;
  logic          stub_ovf;
  logic          stub_unf;
  logic          stub_ovf_q;
  logic          stub_unf_q;
  logic [OW-1:0] stub_res;
  logic [OW-1:0] stub_int;
  int            stub_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_valid <= 1'b0;
      stub_cnt   <= 0;
      stub_res   <= '0;
      stub_int   <= '0;
      stub_ovf_q <= 1'b0;
      stub_unf_q <= 1'b0;
    end else if (pi_start) begin
      stub_valid <= 1'b0;
      stub_cnt   <= 4;
      stub_int   <= pi_new_integral(int'($signed(pi_actual)), int'($signed(pi_setpoint)),
                                    int'(pi_ki), int'(pi_integral_input));
      stub_res   <= pi_out(int'($signed(pi_actual)), int'($signed(pi_setpoint)), int'(pi_kp),
                           pi_new_integral(int'($signed(pi_actual)), int'($signed(pi_setpoint)),
                                           int'(pi_ki), int'(pi_integral_input)));
      stub_ovf_q <= stub_ovf;
      stub_unf_q <= stub_unf;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_valid <= 1'b1;
    end
  end

  assign pi_result_valid    = stub_stuck | stub_valid;
  assign pi_result          = stub_res;
  assign pi_integral_result = stub_int;
  assign pi_overflow        = stub_ovf_q;
  assign pi_underflow       = stub_unf_q;

  // DAC transfer counter.
  int xfer_count;
  initial xfer_count = 0;
  always @(posedge clk) begin
    if (dac_valid && dac_ready) xfer_count <= xfer_count + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks;
  int errors;
  int model_int;        // reference committed integral
  logic [RB-1:0] last_dac;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a sample and waits for the accept edge; returns #1 after it
  // with the live inputs scrambled so operand stability is exercised.
  task automatic do_accept(input int s, input int sp, input int gp, input int gi,
                           output bit ok);
    sample       = s[IW-1:0];
    setpoint     = sp[IW-1:0];
    kp           = gp;
    ki           = gi;
    sample_valid = 1'b1;
    ok           = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      check("accept_wait", {63'd0, sample_ready}, 64'd1);
      sample_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample       = IW'($urandom);
    setpoint     = IW'($urandom);
    kp           = $urandom;
    ki           = $urandom;
  endtask

  // One complete pass with reference-model expectations.
  task automatic run_pass(input int s, input int sp, input int gp, input int gi,
                          input bit ovf, input bit unf, input int ready_hold,
                          input bit clr_done, input bit drop_enable);
    int            exp_new;
    int            exp_res;
    int            exp_commit;
    logic [RB-1:0] exp_dac;
    int            cyc;
    int            x0;
    bit            ok;

    exp_new = pi_new_integral(s, sp, gi, model_int);
    exp_res = pi_out(s, sp, gp, exp_new);
    if (ovf)      exp_dac = 20'h7FFFF;
    else if (unf) exp_dac = 20'h80000;
    else          exp_dac = exp_res[RB-1:0];
    if (clr_done)                         exp_commit = 0;
    else if (ANTI_WINDUP && (ovf || unf)) exp_commit = model_int;
    else                                  exp_commit = exp_new;

    stub_ovf  = ovf;
    stub_unf  = unf;
    dac_ready = (ready_hold == 0);
    do_accept(s, sp, gp, gi, ok);
    if (!ok) return;
    x0 = xfer_count;

    check("launch_pi_start", {63'd0, pi_start}, 64'd1);
    check("launch_busy", {63'd0, busy}, 64'd1);
    check("op_actual", pi_actual, s[IW-1:0]);
    check("op_kp", pi_kp, $unsigned(gp));
    check("op_integral_in", pi_integral_input, $unsigned(model_int));
    if (drop_enable) enable = 1'b0;

    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (clr_done) clear_integral = (cyc == 5);
      if (cyc == 1) check("pi_start_one_cycle", {63'd0, pi_start}, 64'd0);
      if (dac_valid) break;
    end
    clear_integral = 1'b0;
    check("latency", cyc, 64'd6);
    check("dac_data", dac_data, exp_dac);
    check("integral", integral, $unsigned(exp_commit));
    last_dac  = dac_data;
    model_int = exp_commit;

    for (int k = 0; k < ready_hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_dac_valid", {63'd0, dac_valid}, 64'd1);
      check("hold_dac_data", dac_data, exp_dac);
      check("hold_sample_ready", {63'd0, sample_ready}, 64'd0);
    end
    dac_ready = 1'b1;
    @(posedge clk);
    #1;
    check("xfer_dac_valid", {63'd0, dac_valid}, 64'd0);
    check("xfer_busy", {63'd0, busy}, 64'd0);
    check("xfer_count", xfer_count, x0 + 1);
    check("ready_after", {63'd0, sample_ready}, {63'd0, ~drop_enable});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_int = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    bit saw_dac;
    int x0;
    int hold_int;

    checks         = 0;
    errors         = 0;
    model_int      = 0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    clear_integral = 1'b0;
    kp             = '0;
    ki             = '0;
    setpoint       = '0;
    sample         = '0;
    sample_valid   = 1'b0;
    dac_ready      = 1'b1;
    stub_stuck     = 1'b0;
    stub_ovf       = 1'b0;
    stub_unf       = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_pi_start", {63'd0, pi_start}, 64'd0);
    check("rst_operands", {pi_actual, pi_kp}, 64'd0);
    check("rst_integral_in", pi_integral_input, 64'd0);
    check("rst_dac", {dac_valid, dac_data}, 64'd0);
    check("rst_integral", integral, 64'd0);
    check("rst_status", {busy, fault_timeout, sample_ready}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_disabled", {63'd0, sample_ready}, 64'd0);
    enable = 1'b1;
    #1;
    check("ready_enabled", {63'd0, sample_ready}, 64'd1);

    // Nominal pass: 100/40, kp=2, ki=1 -> dac 180, integral 60
    run_pass(100, 40, 2, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("t1_dac_180", last_dac, 64'd180);
    check("t1_integral_60", integral, 64'd60);

    // Same pass from integral 0 with overflow forced
    pulse_reset();
    run_pass(100, 40, 2, 1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t2_dac_max", last_dac, 64'h7FFFF);
    check("t2_integral", integral, ANTI_WINDUP ? 64'd0 : 64'd60);

    // Underflow forced
    run_pass(-300, 50, 4, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t3_dac_min", last_dac, 64'h80000);

    // DAC backpressure for 10 cycles
    run_pass(250, -30, 3, 1, 1'b0, 1'b0, 10, 1'b0, 1'b0);

    // Clear in IDLE, build integral 500, then clear on the completion cycle
    clear_integral = 1'b1;
    @(posedge clk);
    #1;
    clear_integral = 1'b0;
    check("idle_clear", integral, 64'd0);
    model_int = 0;
    run_pass(600, 100, 0, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("integral_500", integral, 64'd500);
    run_pass(110, 100, 3, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("clr_dac_550", last_dac, 64'd550);
    check("clr_integral_0", integral, 64'd0);
    run_pass(90, 100, 1, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Pipeline valid stuck high: never armed, timeout after 15 WAIT cycles
    hold_int   = model_int;
    stub_stuck = 1'b1;
    x0         = xfer_count;
    saw_dac    = 1'b0;
    do_accept(500, 0, 1, 1, ok);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (dac_valid) saw_dac = 1'b1;
      if (k == 15) begin
        check("to_not_early", {63'd0, fault_timeout}, 64'd0);
        check("to_busy_early", {63'd0, busy}, 64'd1);
      end
    end
    stub_stuck = 1'b0;
    check("to_fault", {63'd0, fault_timeout}, 64'd1);
    check("to_idle", {busy, sample_ready}, 64'd1);
    check("to_no_dac", {63'd0, saw_dac}, 64'd0);
    check("to_no_xfer", xfer_count, x0);
    check("to_integral", integral, $unsigned(hold_int));
    run_pass(-120, 30, 2, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("fault_sticky", {63'd0, fault_timeout}, 64'd1);

    // enable dropped mid-pass: pass finishes, then stays idle
    run_pass(77, 7, 1, 1, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    sample_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("disabled_no_accept", {busy, sample_ready}, 64'd0);
    sample_valid = 1'b0;
    enable       = 1'b1;

    // Reset during WAIT, then a normal pass
    do_accept(321, 21, 2, 2, ok);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_wait_busy", {63'd0, busy}, 64'd0);
    check("rst_wait_start_dac", {pi_start, dac_valid}, 64'd0);
    check("rst_wait_fault", {63'd0, fault_timeout}, 64'd0);
    check("rst_wait_integral", integral, 64'd0);
    model_int = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_pass(321, 21, 2, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_integral", integral, 64'd600);

    // Randomized passes
    for (int n = 0; n < 20; n++) begin
      int  rs;
      int  rsp;
      int  rkp;
      int  rki;
      bit  rovf;
      bit  runf;
      rs   = int'($urandom_range(0, 4000)) - 2000;
      rsp  = int'($urandom_range(0, 4000)) - 2000;
      rkp  = int'($urandom_range(0, 23)) - 8;
      rki  = int'($urandom_range(0, 15));
      rovf = ($urandom_range(0, 7) == 0);
      runf = !rovf && ($urandom_range(0, 7) == 0);
      run_pass(rs, rsp, rkp, rki, rovf, runf, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1);
  end

endmodule
